// File: rtl/pc_unit_bp_pkg.sv
// pc_unit_bp_pkg: shared constants for the fetch PC unit and its BTB.
//   - branch condition codes, {N,V,Z} flag bit positions
//   - RUN/HALTED state encoding
//   - 2-bit saturating counter constants and helpers
package pc_unit_bp_pkg;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GEQ    = 3'b100;
  localparam logic [2:0] CC_LEQ    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic cond_true(input logic [2:0] cc, input logic [2:0] f);
    logic n, v, z;
    n = f[FLAG_N];
    v = f[FLAG_V];
    z = f[FLAG_Z];
    case (cc)
      CC_NEQ:  cond_true = ~z;
      CC_EQ:   cond_true = z;
      CC_GT:   cond_true = ~z & ~n;
      CC_LT:   cond_true = n;
      CC_GEQ:  cond_true = z | ~n;
      CC_LEQ:  cond_true = z | n;
      CC_OVFL: cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == CTR_ST) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == CTR_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/pc_unit_bp_btb.sv
// pc_btb: direct-mapped branch target buffer.
//   i_clk, i_rst            clock, sync active-high reset (clears valid bits only)
//   i_rd_word               fetch PC without bit 0 (halfword address)
//   o_rd_taken/o_rd_target  combinational prediction: hit & ctr[1], stored target
//   i_upd_en                resolved branch in EX this cycle
//   i_upd_word              EX PC without bit 0
//   i_upd_taken/_target     resolved outcome
// Reads see the contents before any same-cycle write.
module pc_btb
  import pc_unit_bp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BTB_DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-2:0] i_rd_word,
  output logic             o_rd_taken,
  output logic [WIDTH-1:0] o_rd_target,
  input  logic             i_upd_en,
  input  logic [WIDTH-2:0] i_upd_word,
  input  logic             i_upd_taken,
  input  logic [WIDTH-1:0] i_upd_target
);

  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = WIDTH - IDXW - 1;

  logic [BTB_DEPTH-1:0] r_valid;
  logic [TAGW-1:0]      r_tag    [BTB_DEPTH];
  logic [WIDTH-1:0]     r_target [BTB_DEPTH];
  logic [1:0]           r_ctr    [BTB_DEPTH];

  logic [IDXW-1:0] w_rd_idx, w_upd_idx;
  logic [TAGW-1:0] w_rd_tag, w_upd_tag;
  logic            w_rd_hit, w_upd_hit;

  assign w_rd_idx  = i_rd_word[IDXW-1:0];
  assign w_rd_tag  = i_rd_word[WIDTH-2:IDXW];
  assign w_upd_idx = i_upd_word[IDXW-1:0];
  assign w_upd_tag = i_upd_word[WIDTH-2:IDXW];

  assign w_rd_hit  = r_valid[w_rd_idx] & (r_tag[w_rd_idx] == w_rd_tag);
  assign w_upd_hit = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);

  assign o_rd_taken  = w_rd_hit & r_ctr[w_rd_idx][1];
  assign o_rd_target = r_target[w_rd_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_upd_en) begin
      if (w_upd_hit) begin
        if (i_upd_taken) begin
          r_ctr[w_upd_idx]    <= ctr_inc(r_ctr[w_upd_idx]);
          r_target[w_upd_idx] <= i_upd_target;
        end else begin
          r_ctr[w_upd_idx] <= ctr_dec(r_ctr[w_upd_idx]);
        end
      end else if (i_upd_taken) begin
        // Allocate weakly-taken; a not-taken miss leaves the slot alone.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_ctr[w_upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/pc_unit_bp.sv
// pc_unit_bp: fetch PC register with BTB prediction, EX branch resolution,
// mispredict redirect and RUN/HALTED state.
//   i_clk, i_rst              clock, sync active-high reset
//   i_stall, i_hlt            hold PC; HLT decoded on the correct path
//   o_pc                      registered fetch address
//   o_pred_taken/o_pred_target prediction for the instruction at o_pc
//   i_ex_*                    branch info from EX (valid, kind, cond, flags,
//                             imm, reg target, pc, carried prediction)
//   o_redirect                combinational mispredict / flush
//   o_halted                  unit is in HALTED
module pc_unit_bp
  import pc_unit_bp_pkg::*;
#(
  parameter int                WIDTH     = 16,
  parameter int                IMM_W     = 9,
  parameter int                BTB_DEPTH = 8,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_hlt,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pred_taken,
  output logic [WIDTH-1:0] o_pred_target,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_br_imm,
  input  logic             i_ex_is_br_reg,
  input  logic [2:0]       i_ex_cond,
  input  logic [2:0]       i_ex_flags,
  input  logic [IMM_W-1:0] i_ex_imm,
  input  logic [WIDTH-1:0] i_ex_reg_target,
  input  logic [WIDTH-1:0] i_ex_pc,
  input  logic             i_ex_pred_taken,
  input  logic [WIDTH-1:0] i_ex_pred_target,
  output logic             o_redirect,
  output logic             o_halted
);

  logic [WIDTH-1:0] r_pc;
  state_e           r_state, w_state_nxt;

  logic [WIDTH-1:0] w_pc_nxt, w_ex_pc_p2, w_off, w_target, w_redir_addr;
  logic             w_is_br, w_taken, w_mispred, w_redirect;
  logic             w_pred_taken;
  logic [WIDTH-1:0] w_pred_target;

  // EX resolution. Offset is a signed halfword count, so sign-extend and
  // append a zero bit in one step.
  assign w_is_br    = i_ex_is_br_imm | i_ex_is_br_reg;
  assign w_ex_pc_p2 = i_ex_pc + WIDTH'(2);
  assign w_off      = {{(WIDTH-IMM_W-1){i_ex_imm[IMM_W-1]}}, i_ex_imm, 1'b0};
  assign w_target   = i_ex_is_br_imm ? (w_ex_pc_p2 + w_off) : i_ex_reg_target;
  assign w_taken    = i_ex_valid & w_is_br & cond_true(i_ex_cond, i_ex_flags);

  // Non-branches carried as predicted-taken also mispredict here.
  assign w_mispred  = i_ex_valid &
                      ((w_taken != i_ex_pred_taken) |
                       (w_taken & (i_ex_pred_target != w_target)));
  // HALTED cannot legitimately see a mispredict; any such pulse is dropped.
  assign w_redirect   = w_mispred & (r_state == ST_RUN);
  assign w_redir_addr = w_taken ? w_target : w_ex_pc_p2;

  pc_btb #(
    .WIDTH     (WIDTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rd_word    (r_pc[WIDTH-1:1]),
    .o_rd_taken   (w_pred_taken),
    .o_rd_target  (w_pred_target),
    .i_upd_en     (i_ex_valid & w_is_br),
    .i_upd_word   (i_ex_pc[WIDTH-1:1]),
    .i_upd_taken  (w_taken),
    .i_upd_target (w_target)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // A same-cycle redirect means the hlt was fetched on the wrong path.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (i_hlt & ~w_redirect) w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_HALTED;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc + WIDTH'(2);
    if (w_redirect)                                     w_pc_nxt = w_redir_addr;
    else if ((r_state == ST_HALTED) | i_hlt | i_stall) w_pc_nxt = r_pc;
    else if (w_pred_taken)                              w_pc_nxt = w_pred_target;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pc <= RESET_PC;
    else       r_pc <= w_pc_nxt;
  end

  assign o_pc          = r_pc;
  assign o_pred_taken  = w_pred_taken;
  assign o_pred_target = w_pred_target;
  assign o_redirect    = w_redirect;
  assign o_halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_unit_bp.sv
module tb_pc_unit_bp;

  logic        clk = 1'b0;
  logic        rst, stall, hlt;
  logic [15:0] pc, pred_target;
  logic        pred_taken;
  logic        ex_valid, ex_is_br_imm, ex_is_br_reg;
  logic [2:0]  ex_cond, ex_flags;
  logic [8:0]  ex_imm;
  logic [15:0] ex_reg_target, ex_pc, ex_pred_target;
  logic        ex_pred_taken;
  logic        redirect, halted;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  pc_unit_bp dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_hlt            (hlt),
    .o_pc             (pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_ex_valid       (ex_valid),
    .i_ex_is_br_imm   (ex_is_br_imm),
    .i_ex_is_br_reg   (ex_is_br_reg),
    .i_ex_cond        (ex_cond),
    .i_ex_flags       (ex_flags),
    .i_ex_imm         (ex_imm),
    .i_ex_reg_target  (ex_reg_target),
    .i_ex_pc          (ex_pc),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .o_redirect       (redirect),
    .o_halted         (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_br_imm = 0; ex_is_br_reg = 0; ex_cond = 0; ex_flags = 0;
    ex_imm = 0; ex_reg_target = 0; ex_pc = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic drive_ex(input logic [15:0] p, input logic [8:0] imm,
                          input logic [15:0] rt, input logic [2:0] cc,
                          input logic [2:0] fl, input logic bi, input logic br,
                          input logic pt, input logic [15:0] ptg);
    ex_valid = 1; ex_pc = p; ex_imm = imm; ex_reg_target = rt; ex_cond = cc;
    ex_flags = fl; ex_is_br_imm = bi; ex_is_br_reg = br;
    ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  // Steer fetch: a non-branch at a-2 carried as predicted-taken redirects to a.
  task automatic jump_to(input logic [15:0] a);
    drive_ex(a - 16'd2, 9'd0, 16'd0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 16'd0);
    tick();
    clear_ex();
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; hlt = 0; clear_ex();
    ex_pred_taken = 1;  // idle EX slot must never redirect
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h want 0000", pc); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
    n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    ex_pred_taken = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 4; i++) sb_q.push_back(16'(2 * i));
    for (int i = 0; i < 4; i++) begin
      exp_pc = sb_q.pop_front();
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL free_run_pc: got %h want %h", pc, exp_pc); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL free_run_pred: got %b want 0", pred_taken); end
      tick();
    end
  endtask

  task automatic test_cold_eq();
    drive_ex(16'h0010, 9'h005, 16'h0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 16'h0);
    sb_q.push_back(16'h001C);
    @(negedge clk);
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL cold_redirect: got %b want 1", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL cold_pc: got %h want %h", pc, exp_pc); end
    clear_ex();
  endtask

  task automatic test_warm_hit();
    drive_ex(16'h000E, 9'h0, 16'h0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 16'h0);
    sb_q.push_back(16'h0010);
    @(negedge clk);
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL nonbr_pred_redirect: got %b want 1", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL warm_jump_pc: got %h want %h", pc, exp_pc); end
    // Matching resolution of the same branch while it is being fetched again.
    drive_ex(16'h0010, 9'h005, 16'h0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b1, 16'h001C);
    sb_q.push_back(16'h001C);
    @(negedge clk);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL warm_pred: got %b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 16'h001C) begin n_err++; $display("FAIL warm_target: got %h want 001c", pred_target); end
    n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL warm_redirect: got %b want 0", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL warm_pc: got %h want %h", pc, exp_pc); end
    clear_ex();
  endtask

  // Counter is 11 here: one not-taken keeps it predicting, the second does not.
  task automatic test_not_taken();
    drive_ex(16'h0010, 9'h005, 16'h0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b1, 16'h001C);
    sb_q.push_back(16'h0012);
    @(negedge clk);
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL nt1_redirect: got %b want 1", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL nt1_pc: got %h want %h", pc, exp_pc); end
    clear_ex();
    sb_q.push_back(16'h0010);
    jump_to(16'h0010);
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL nt_jump_pc: got %h want %h", pc, exp_pc); end
    drive_ex(16'h0010, 9'h005, 16'h0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b1, 16'h001C);
    sb_q.push_back(16'h0012);
    @(negedge clk);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL nt_ctr10_pred: got %b want 1", pred_taken); end
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL nt2_redirect: got %b want 1", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL nt2_pc: got %h want %h", pc, exp_pc); end
    clear_ex();
    sb_q.push_back(16'h0010);
    jump_to(16'h0010);
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL nt_jump2_pc: got %h want %h", pc, exp_pc); end
    sb_q.push_back(16'h0012);
    @(negedge clk);
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL nt_ctr01_pred: got %b want 0", pred_taken); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL nt_fall_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_neg_offset();
    drive_ex(16'h0040, 9'h1FF, 16'h0, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 16'h0);
    sb_q.push_back(16'h0040);
    @(negedge clk);
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL neg_redirect: got %b want 1", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL neg_pc: got %h want %h", pc, exp_pc); end
    clear_ex();
    sb_q.push_back(16'h0040);
    @(negedge clk);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL neg_pred: got %b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 16'h0040) begin n_err++; $display("FAIL neg_target: got %h want 0040", pred_target); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL neg_loop_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_br_target();
    drive_ex(16'h0020, 9'h0, 16'h1000, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 16'h0);
    sb_q.push_back(16'h1000);
    @(negedge clk);
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL br1_redirect: got %b want 1", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL br1_pc: got %h want %h", pc, exp_pc); end
    drive_ex(16'h0020, 9'h0, 16'h1234, 3'b111, 3'b000, 1'b0, 1'b1, 1'b1, 16'h1000);
    sb_q.push_back(16'h1234);
    @(negedge clk);
    n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL br2_redirect: got %b want 1", redirect); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL br2_pc: got %h want %h", pc, exp_pc); end
    clear_ex();
    sb_q.push_back(16'h0020);
    jump_to(16'h0020);
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL br_jump_pc: got %h want %h", pc, exp_pc); end
    sb_q.push_back(16'h1234);
    @(negedge clk);
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL br_pred: got %b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 16'h1234) begin n_err++; $display("FAIL br_target: got %h want 1234", pred_target); end
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL br_pred_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_wrap();
    sb_q.push_back(16'hFFFE);
    jump_to(16'hFFFE);
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL wrap_jump_pc: got %h want %h", pc, exp_pc); end
    sb_q.push_back(16'h0000);
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL wrap_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_stall();
    sb_q.push_back(16'h0100);
    jump_to(16'h0100);
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL stall_jump_pc: got %h want %h", pc, exp_pc); end
    stall = 1;
    for (int i = 0; i < 3; i++) sb_q.push_back(16'h0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = sb_q.pop_front();
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL stall_hold_pc: got %h want %h", pc, exp_pc); end
    end
    sb_q.push_back(16'h0180);  // redirect beats stall
    jump_to(16'h0180);
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL stall_redirect_pc: got %h want %h", pc, exp_pc); end
    stall = 0;
    sb_q.push_back(16'h0182);
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL stall_release_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_hlt_redirect();
    hlt = 1;
    sb_q.push_back(16'h0200);
    jump_to(16'h0200);
    hlt = 0;
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL hltr_pc: got %h want %h", pc, exp_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL hltr_halted: got %b want 0", halted); end
    sb_q.push_back(16'h0202);
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL hltr_next_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_halt();
    hlt = 1;
    sb_q.push_back(16'h0202);
    tick();
    hlt = 0;
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL halt_pc: got %h want %h", pc, exp_pc); end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_state: got %b want 1", halted); end
    for (int i = 0; i < 12; i++) sb_q.push_back(16'h0202);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) drive_ex(16'h03FE, 9'h0, 16'h0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 16'h0);
      else        clear_ex();
      tick();
      exp_pc = sb_q.pop_front();
      n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL halt_frozen_pc[%0d]: got %h want %h", i, pc, exp_pc); end
    end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", halted); end
    // Reset with a pending redirect and hlt: both discarded.
    drive_ex(16'h03FE, 9'h0, 16'h0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b1, 16'h0);
    hlt = 1; rst = 1;
    sb_q.push_back(16'h0000);
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL halt_rst_pc: got %h want %h", pc, exp_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_rst_state: got %b want 0", halted); end
    rst = 0; hlt = 0; clear_ex();
    sb_q.push_back(16'h0002);
    tick();
    exp_pc = sb_q.pop_front();
    n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL post_rst_pc: got %h want %h", pc, exp_pc); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_cold_eq();
    test_warm_hit();
    test_not_taken();
    test_neg_offset();
    test_br_target();
    test_wrap();
    test_stall();
    test_hlt_redirect();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
